// File: rtl/z80fi_pkg.sv
// Shared z80fi types: I/O cycle FSM states and the per-instruction I/O record.
package z80fi_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  // Bus-cycle tracker states; the non-IDLE states also tag the kind of a completed cycle.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_CYC   = 2'd1,
    WR_CYC   = 2'd2,
    INTA_CYC = 2'd3
  } io_state_e;

  // One instruction's worth of I/O evidence.
  typedef struct packed {
    logic              io_rd;
    logic              io_wr;
    logic              inta;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] wdata;
  } io_rec_t;

endpackage

// File: rtl/z80fi_io_capture_if.sv
// Core bus strobes in, retired I/O record out.
// Z80FI_INTA_CAPTURE_EN adds the interrupt-acknowledge record fields.
interface z80fi_io_capture_if;
  import z80fi_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              iorq_n;
  logic              rd_n;
  logic              wr_n;
  logic              m1_n;
  logic              wait_n;
  logic              insn_retire;

  logic              rec_valid;
  logic              rec_io_rd;
  logic              rec_io_wr;
  logic [ADDR_W-1:0] rec_raddr;
  logic [ADDR_W-1:0] rec_waddr;
  logic [DATA_W-1:0] rec_rdata;
  logic [DATA_W-1:0] rec_wdata;
  logic              io_overflow;
`ifdef Z80FI_INTA_CAPTURE_EN
  logic              rec_inta;
  logic [DATA_W-1:0] rec_vector;
`endif

  // Core / bench side: drives the bus, observes records.
  modport master (
`ifdef Z80FI_INTA_CAPTURE_EN
    input  rec_inta, input rec_vector,
`endif
    output addr, data_in, data_out, iorq_n, rd_n, wr_n, m1_n, wait_n, insn_retire,
    input  rec_valid, rec_io_rd, rec_io_wr, rec_raddr, rec_waddr, rec_rdata, rec_wdata,
           io_overflow
  );

  // Capture side: observes the bus, produces records.
  modport slave (
`ifdef Z80FI_INTA_CAPTURE_EN
    output rec_inta, output rec_vector,
`endif
    input  addr, data_in, data_out, iorq_n, rd_n, wr_n, m1_n, wait_n, insn_retire,
    output rec_valid, rec_io_rd, rec_io_wr, rec_raddr, rec_waddr, rec_rdata, rec_wdata,
           io_overflow
  );

endinterface

// File: rtl/z80fi_io_capture_cycle_fsm.sv
// Strobe decode for one Z80 I/O bus cycle; pulses cyc_done_c_o when iorq_n returns high.
// Z80FI_INTA_CAPTURE_EN enables tracking of interrupt-acknowledge cycles.
module z80fi_io_cycle_fsm
  import z80fi_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic [DATA_W-1:0] data_out_i,
  input  logic              iorq_n_i,
  input  logic              rd_n_i,
  input  logic              wr_n_i,
  input  logic              m1_n_i,
  input  logic              wait_n_i,
  output logic              cyc_done_c_o,
  output io_state_e         cyc_kind_o,
  output logic [ADDR_W-1:0] cyc_addr_o,
  output logic [DATA_W-1:0] cyc_data_o
);

  io_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] hold_q;

  // Cycle tracking: latch on entry, sample read data on non-wait clocks, exit on iorq_n high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!iorq_n_i && m1_n_i && !rd_n_i) begin
            state_q <= RD_CYC;
            addr_q  <= addr_i;
          end else if (!iorq_n_i && m1_n_i && !wr_n_i) begin
            state_q <= WR_CYC;
            addr_q  <= addr_i;
            wdata_q <= data_out_i;
`ifdef Z80FI_INTA_CAPTURE_EN
          end else if (!iorq_n_i && !m1_n_i) begin
            state_q <= INTA_CYC;
            addr_q  <= addr_i;
`endif
          end
        end
        RD_CYC, INTA_CYC: begin
          if (iorq_n_i) begin
            state_q <= IDLE;
          end else if (wait_n_i) begin
            hold_q <= data_in_i;
          end
        end
        WR_CYC: begin
          if (iorq_n_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Completion is seen in the same clock iorq_n is sampled high, so it can join a retiring record.
  assign cyc_done_c_o = (state_q != IDLE) && iorq_n_i;
  assign cyc_kind_o   = state_q;
  assign cyc_addr_o   = addr_q;
  assign cyc_data_o   = (state_q == WR_CYC) ? wdata_q : hold_q;

endmodule

// File: rtl/z80fi_io_capture.sv
// Per-instruction I/O record capture for the Z80 formal interface.
// Z80FI_INTA_CAPTURE_EN: also record interrupt-acknowledge vectors (rec_inta/rec_vector).
module z80fi_io_capture
  import z80fi_pkg::*;
#(
  parameter bit STRICT = 1'b1
) (
  input logic               clk,
  input logic               reset_n,
  z80fi_io_capture_if.slave bus
);

  logic              cyc_done_c;
  io_state_e         cyc_kind;
  logic [ADDR_W-1:0] cyc_addr;
  logic [DATA_W-1:0] cyc_data;

  io_rec_t           pend_q, pend_d;
  logic              dup_c;
  logic              rec_valid_q, io_overflow_q;
  logic              rec_io_rd_q, rec_io_wr_q;
  logic [ADDR_W-1:0] rec_raddr_q, rec_waddr_q;
  logic [DATA_W-1:0] rec_rdata_q, rec_wdata_q;
`ifdef Z80FI_INTA_CAPTURE_EN
  logic [DATA_W-1:0] vec_pend_q, vec_pend_d, rec_vector_q;
  logic              rec_inta_q;
`endif

  z80fi_io_cycle_fsm u_cycle_fsm (
    .clk          (clk),
    .reset_n      (reset_n),
    .addr_i       (bus.addr),
    .data_in_i    (bus.data_in),
    .data_out_i   (bus.data_out),
    .iorq_n_i     (bus.iorq_n),
    .rd_n_i       (bus.rd_n),
    .wr_n_i       (bus.wr_n),
    .m1_n_i       (bus.m1_n),
    .wait_n_i     (bus.wait_n),
    .cyc_done_c_o (cyc_done_c),
    .cyc_kind_o   (cyc_kind),
    .cyc_addr_o   (cyc_addr),
    .cyc_data_o   (cyc_data)
  );

  // Fold a completed cycle into the pending record; flag a repeat of the same kind.
  always_comb begin
    pend_d = pend_q;
    dup_c  = 1'b0;
`ifdef Z80FI_INTA_CAPTURE_EN
    vec_pend_d = vec_pend_q;
`endif
    if (cyc_done_c) begin
      unique case (cyc_kind)
        RD_CYC: begin
          dup_c        = pend_q.io_rd;
          pend_d.io_rd = 1'b1;
          pend_d.raddr = cyc_addr;
          pend_d.rdata = cyc_data;
        end
        WR_CYC: begin
          dup_c        = pend_q.io_wr;
          pend_d.io_wr = 1'b1;
          pend_d.waddr = cyc_addr;
          pend_d.wdata = cyc_data;
        end
        INTA_CYC: begin
          dup_c       = pend_q.inta;
          pend_d.inta = 1'b1;
`ifdef Z80FI_INTA_CAPTURE_EN
          vec_pend_d  = cyc_data;
`endif
        end
        default: ;
      endcase
    end
  end

  // Retirement publishes the updated record and starts a fresh one; overflow is sticky.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q        <= '0;
      rec_valid_q   <= 1'b0;
      io_overflow_q <= 1'b0;
      rec_io_rd_q   <= 1'b0;
      rec_io_wr_q   <= 1'b0;
      rec_raddr_q   <= '0;
      rec_waddr_q   <= '0;
      rec_rdata_q   <= '0;
      rec_wdata_q   <= '0;
`ifdef Z80FI_INTA_CAPTURE_EN
      vec_pend_q    <= '0;
      rec_inta_q    <= 1'b0;
      rec_vector_q  <= '0;
`endif
    end else begin
      rec_valid_q <= bus.insn_retire;
      if (STRICT && dup_c) begin
        io_overflow_q <= 1'b1;
      end
      if (bus.insn_retire) begin
        rec_io_rd_q  <= pend_d.io_rd;
        rec_io_wr_q  <= pend_d.io_wr;
        rec_raddr_q  <= pend_d.raddr;
        rec_waddr_q  <= pend_d.waddr;
        rec_rdata_q  <= pend_d.rdata;
        rec_wdata_q  <= pend_d.wdata;
        pend_q       <= '0;
`ifdef Z80FI_INTA_CAPTURE_EN
        rec_inta_q   <= pend_d.inta;
        rec_vector_q <= vec_pend_d;
        vec_pend_q   <= '0;
`endif
      end else begin
        pend_q       <= pend_d;
`ifdef Z80FI_INTA_CAPTURE_EN
        vec_pend_q   <= vec_pend_d;
`endif
      end
    end
  end

  assign bus.rec_valid   = rec_valid_q;
  assign bus.rec_io_rd   = rec_io_rd_q;
  assign bus.rec_io_wr   = rec_io_wr_q;
  assign bus.rec_raddr   = rec_raddr_q;
  assign bus.rec_waddr   = rec_waddr_q;
  assign bus.rec_rdata   = rec_rdata_q;
  assign bus.rec_wdata   = rec_wdata_q;
  assign bus.io_overflow = io_overflow_q;
`ifdef Z80FI_INTA_CAPTURE_EN
  assign bus.rec_inta    = rec_inta_q;
  assign bus.rec_vector  = rec_vector_q;
`endif

endmodule

// File: tb/tb_z80fi_io_capture.sv
// Bench for z80fi_io_capture: STRICT=1 and STRICT=0 instances share one stimulus stream
// and are compared against an op-list reference model of each instruction's I/O.
module tb_z80fi_io_capture;
  import z80fi_pkg::*;

`ifdef Z80FI_INTA_CAPTURE_EN
  localparam int unsigned GOT_W = 61;
`else
  localparam int unsigned GOT_W = 52;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  z80fi_io_capture_if bus0 ();
  z80fi_io_capture_if bus1 ();

  assign bus1.addr        = bus0.addr;
  assign bus1.data_in     = bus0.data_in;
  assign bus1.data_out    = bus0.data_out;
  assign bus1.iorq_n      = bus0.iorq_n;
  assign bus1.rd_n        = bus0.rd_n;
  assign bus1.wr_n        = bus0.wr_n;
  assign bus1.m1_n        = bus0.m1_n;
  assign bus1.wait_n      = bus0.wait_n;
  assign bus1.insn_retire = bus0.insn_retire;

  z80fi_io_capture #(.STRICT(1'b1)) dut_s (.clk(clk), .reset_n(reset_n), .bus(bus0));
  z80fi_io_capture #(.STRICT(1'b0)) dut_n (.clk(clk), .reset_n(reset_n), .bus(bus1));

  int passed = 0;
  int total  = 0;

  // Reference model: the I/O operations seen during the current instruction.
  typedef struct {
    int          kind;   // 0 read, 1 write, 2 acknowledge
    logic [15:0] a;
    logic [7:0]  d;
  } op_t;
  op_t ops[$];

  logic        exp_rd, exp_wr, exp_inta, exp_ovf;
  logic [15:0] exp_raddr, exp_waddr;
  logic [7:0]  exp_rdata, exp_wdata, exp_vec;

  logic [GOT_W-1:0] g, e;

  task automatic model_clear_rec();
    exp_rd = 1'b0; exp_wr = 1'b0; exp_inta = 1'b0;
    exp_raddr = '0; exp_waddr = '0; exp_rdata = '0; exp_wdata = '0; exp_vec = '0;
  endtask

  // Record = last op of each kind; any kind seen twice means overflow under STRICT.
  task automatic model_retire();
    int cnt[3];
    cnt = '{0, 0, 0};
    model_clear_rec();
    foreach (ops[i]) begin
      cnt[ops[i].kind]++;
      case (ops[i].kind)
        0: begin exp_rd = 1'b1; exp_raddr = ops[i].a; exp_rdata = ops[i].d; end
        1: begin exp_wr = 1'b1; exp_waddr = ops[i].a; exp_wdata = ops[i].d; end
        default: begin exp_inta = 1'b1; exp_vec = ops[i].d; end
      endcase
    end
    if (cnt[0] > 1 || cnt[1] > 1 || cnt[2] > 1) exp_ovf = 1'b1;
    ops.delete();
  endtask

  function automatic logic [GOT_W-1:0] exp_vec_of(input logic valid, input bit strict);
    return {valid, exp_rd, exp_wr, exp_raddr, exp_rdata, exp_waddr, exp_wdata,
            strict ? exp_ovf : 1'b0
`ifdef Z80FI_INTA_CAPTURE_EN
            , exp_inta, exp_vec
`endif
           };
  endfunction

  function automatic logic [GOT_W-1:0] got_s();
    return {bus0.rec_valid, bus0.rec_io_rd, bus0.rec_io_wr, bus0.rec_raddr, bus0.rec_rdata,
            bus0.rec_waddr, bus0.rec_wdata, bus0.io_overflow
`ifdef Z80FI_INTA_CAPTURE_EN
            , bus0.rec_inta, bus0.rec_vector
`endif
           };
  endfunction

  function automatic logic [GOT_W-1:0] got_n();
    return {bus1.rec_valid, bus1.rec_io_rd, bus1.rec_io_wr, bus1.rec_raddr, bus1.rec_rdata,
            bus1.rec_waddr, bus1.rec_wdata, bus1.io_overflow
`ifdef Z80FI_INTA_CAPTURE_EN
            , bus1.rec_inta, bus1.rec_vector
`endif
           };
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus0.iorq_n = 1'b1; bus0.rd_n = 1'b1; bus0.wr_n = 1'b1; bus0.m1_n = 1'b1;
    bus0.wait_n = 1'b1; bus0.insn_retire = 1'b0;
  endtask

  task automatic drive_read(input logic [15:0] a, input logic [7:0] d, input int waits,
                            input bit ret);
    bus0.addr = a; bus0.iorq_n = 1'b0; bus0.rd_n = 1'b0; bus0.wait_n = 1'b1;
    bus0.data_in = (waits > 0) ? 8'hFF : d;
    tick();
    for (int i = 0; i < waits; i++) begin
      bus0.wait_n = 1'b0; bus0.data_in = 8'hFF;
      tick();
    end
    bus0.wait_n = 1'b1; bus0.data_in = d;
    tick();
    bus0.iorq_n = 1'b1; bus0.rd_n = 1'b1; bus0.insn_retire = ret;
    tick();
    bus0.insn_retire = 1'b0; bus0.addr = 16'($urandom); bus0.data_in = 8'($urandom);
    ops.push_back('{0, a, d});
  endtask

  task automatic drive_write(input logic [15:0] a, input logic [7:0] d, input bit ret);
    bus0.addr = a; bus0.data_out = d; bus0.iorq_n = 1'b0; bus0.wr_n = 1'b0;
    tick();
    tick();
    bus0.iorq_n = 1'b1; bus0.wr_n = 1'b1; bus0.insn_retire = ret;
    bus0.data_out = 8'($urandom);
    tick();
    bus0.insn_retire = 1'b0; bus0.addr = 16'($urandom);
    ops.push_back('{1, a, d});
  endtask

  task automatic drive_inta(input logic [7:0] v, input bit ret);
    bus0.m1_n = 1'b0; bus0.iorq_n = 1'b0; bus0.data_in = v;
    tick();
    tick();
    bus0.iorq_n = 1'b1; bus0.m1_n = 1'b1; bus0.insn_retire = ret;
    tick();
    bus0.insn_retire = 1'b0; bus0.data_in = 8'($urandom);
`ifdef Z80FI_INTA_CAPTURE_EN
    ops.push_back('{2, 16'h0000, v});
`endif
  endtask

  task automatic do_retire();
    bus0.insn_retire = 1'b1;
    tick();
    bus0.insn_retire = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    bus0.addr = '0; bus0.data_in = '0; bus0.data_out = '0;
    #1 reset_n = 1'b0;
    tick(); tick();
    ops.delete(); model_clear_rec(); exp_ovf = 1'b0;
    g = got_s(); e = exp_vec_of(1'b0, 1'b1); total++;
    if (g !== e) $display("FAIL reset_strict got=%h exp=%h", g, e); else passed++;
    g = got_n(); e = exp_vec_of(1'b0, 1'b0); total++;
    if (g !== e) $display("FAIL reset_nonstrict got=%h exp=%h", g, e); else passed++;
    @(negedge clk) reset_n = 1'b1;
    tick();
  endtask

  task automatic test_in_read();
    drive_read(16'h12FE, 8'h5A, 0, 1'b0);
    do_retire(); model_retire();
    g = got_s(); e = exp_vec_of(1'b1, 1'b1); total++;
    if (g !== e) $display("FAIL in_read got=%h exp=%h", g, e); else passed++;
    tick();
    g = got_s(); e = exp_vec_of(1'b0, 1'b1); total++;
    if (g !== e) $display("FAIL in_read_hold got=%h exp=%h", g, e); else passed++;
  endtask

  task automatic test_out_write();
    drive_write(16'h7734, 8'h77, 1'b0);
    do_retire(); model_retire();
    g = got_s(); e = exp_vec_of(1'b1, 1'b1); total++;
    if (g !== e) $display("FAIL out_write got=%h exp=%h", g, e); else passed++;
    g = got_n(); e = exp_vec_of(1'b1, 1'b0); total++;
    if (g !== e) $display("FAIL out_write_ns got=%h exp=%h", g, e); else passed++;
  endtask

  task automatic test_wait_states();
    drive_read(16'h00A5, 8'h3C, 3, 1'b0);
    do_retire(); model_retire();
    g = got_s(); e = exp_vec_of(1'b1, 1'b1); total++;
    if (g !== e) $display("FAIL wait_states got=%h exp=%h", g, e); else passed++;
    g = got_n(); e = exp_vec_of(1'b1, 1'b0); total++;
    if (g !== e) $display("FAIL wait_states_ns got=%h exp=%h", g, e); else passed++;
  endtask

  task automatic test_overflow();
    drive_read(16'h1111, 8'h11, 0, 1'b0);
    drive_read(16'h2222, 8'h22, 1, 1'b0);
    do_retire(); model_retire();
    g = got_s(); e = exp_vec_of(1'b1, 1'b1); total++;
    if (g !== e) $display("FAIL overflow_strict got=%h exp=%h", g, e); else passed++;
    g = got_n(); e = exp_vec_of(1'b1, 1'b0); total++;
    if (g !== e) $display("FAIL overflow_nonstrict got=%h exp=%h", g, e); else passed++;
  endtask

  task automatic test_retire_same_cycle();
    drive_write(16'h4455, 8'h66, 1'b0);
    drive_read(16'hBEEF, 8'hC3, 0, 1'b1);
    model_retire();
    g = got_s(); e = exp_vec_of(1'b1, 1'b1); total++;
    if (g !== e) $display("FAIL same_cycle got=%h exp=%h", g, e); else passed++;
    g = got_n(); e = exp_vec_of(1'b1, 1'b0); total++;
    if (g !== e) $display("FAIL same_cycle_ns got=%h exp=%h", g, e); else passed++;
    do_retire(); model_retire();
    g = got_s(); e = exp_vec_of(1'b1, 1'b1); total++;
    if (g !== e) $display("FAIL empty_after got=%h exp=%h", g, e); else passed++;
    g = got_n(); e = exp_vec_of(1'b1, 1'b0); total++;
    if (g !== e) $display("FAIL empty_after_ns got=%h exp=%h", g, e); else passed++;
  endtask

  task automatic test_inta();
    drive_inta(8'hFF, 1'b0);
    do_retire(); model_retire();
    g = got_s(); e = exp_vec_of(1'b1, 1'b1); total++;
    if (g !== e) $display("FAIL inta got=%h exp=%h", g, e); else passed++;
    g = got_n(); e = exp_vec_of(1'b1, 1'b0); total++;
    if (g !== e) $display("FAIL inta_ns got=%h exp=%h", g, e); else passed++;
  endtask

  task automatic test_reset_mid_read();
    bus0.addr = 16'h9876; bus0.iorq_n = 1'b0; bus0.rd_n = 1'b0; bus0.data_in = 8'hE1;
    tick(); tick();
    reset_n = 1'b0;
    #2;
    ops.delete(); model_clear_rec(); exp_ovf = 1'b0;
    g = got_s(); e = exp_vec_of(1'b0, 1'b1); total++;
    if (g !== e) $display("FAIL mid_reset got=%h exp=%h", g, e); else passed++;
    g = got_n(); e = exp_vec_of(1'b0, 1'b0); total++;
    if (g !== e) $display("FAIL mid_reset_ns got=%h exp=%h", g, e); else passed++;
    set_idle();
    @(negedge clk) reset_n = 1'b1;
    tick();
    do_retire(); model_retire();
    g = got_s(); e = exp_vec_of(1'b1, 1'b1); total++;
    if (g !== e) $display("FAIL post_reset_rec got=%h exp=%h", g, e); else passed++;
    g = got_n(); e = exp_vec_of(1'b1, 1'b0); total++;
    if (g !== e) $display("FAIL post_reset_rec_ns got=%h exp=%h", g, e); else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int  nops;
      bit  ret;
      nops = int'($urandom_range(0, 3));
      ret  = 1'b0;
      for (int j = 0; j < nops; j++) begin
        int k;
        k   = int'($urandom_range(0, 2));
        ret = (j == nops - 1) && ($urandom_range(0, 3) == 0);
        case (k)
          0:       drive_read(16'($urandom), 8'($urandom), int'($urandom_range(0, 2)), ret);
          1:       drive_write(16'($urandom), 8'($urandom), ret);
          default: drive_inta(8'($urandom), ret);
        endcase
        for (int w = 0; w < int'($urandom_range(0, 1)); w++) tick();
      end
      if (!ret) do_retire();
      model_retire();
      g = got_s(); e = exp_vec_of(ret ? 1'b0 : 1'b1, 1'b1);
      if (ret) e = exp_vec_of(g[GOT_W-1], 1'b1);
      total++;
      if (ret) begin
        if (g !== e) $display("FAIL random_ret[%0d] got=%h exp=%h", n, g, e); else passed++;
      end else begin
        if (g !== e) $display("FAIL random[%0d] got=%h exp=%h", n, g, e); else passed++;
      end
      g = got_n(); e = exp_vec_of(g[GOT_W-1], 1'b0); total++;
      if (g !== e) $display("FAIL random_ns[%0d] got=%h exp=%h", n, g, e); else passed++;
      tick();
    end
  endtask

  initial begin
    exp_ovf = 1'b0;
    model_clear_rec();
    test_reset();
    test_in_read();
    test_out_write();
    test_wait_states();
    test_overflow();
    test_retire_same_cycle();
    test_inta();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/z80fi_io_capture.md
# z80fi_io_capture

Bus-side capture stage for the Z80 formal interface. It watches the core's pin-level I/O bus cycles and records, per retired instruction, the I/O read and write address and data. These records drive the `z80fi_bus_raddr/rdata` and `z80fi_bus_waddr/wdata` fields and the `SPEC_IO_RD`/`SPEC_IO_WR` evidence that instruction spec modules (IN/OUT/INI/OUTI families) check against. It sits between the core's external bus and the z80fi retirement record.

## Interface
Parameters:
- `STRICT`, default 1: when 1, a second I/O cycle of the same direction within one instruction sets `io_overflow`. When 0, it silently overwrites the record.

Ports (clock and reset first):
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `addr` in 16: core address bus.
- `data_in` in 8: data driven to the core (port read data).
- `data_out` in 8: data driven by the core (port write data).
- `iorq_n`, `rd_n`, `wr_n`, `m1_n`, `wait_n` in 1 each: core bus strobes, synchronous to `clk`.
- `insn_retire` in 1: one-cycle pulse marking the last cycle of an instruction.
- `rec_valid` out 1: one-cycle pulse carrying a completed record.
- `rec_io_rd`, `rec_io_wr` out 1 each: record contains a read / a write.
- `rec_raddr`, `rec_waddr` out 16 each: recorded I/O addresses.
- `rec_rdata`, `rec_wdata` out 8 each: recorded I/O data.
- `io_overflow` out 1: sticky error flag. Cleared only by reset.
- `rec_inta` out 1 and `rec_vector` out 8: present only with the macro enabled.

## Operation
- FSM states: `IDLE`, `RD_CYC`, `WR_CYC`, `INTA_CYC`.
- `IDLE` → `RD_CYC` when `!iorq_n && !rd_n && m1_n`. Latch `addr` on entry.
- `IDLE` → `WR_CYC` when `!iorq_n && !wr_n && m1_n`. Latch `addr` and `data_out` on entry.
- `IDLE` → `INTA_CYC` when `!iorq_n && !m1_n`. This transition exists only with the macro enabled; otherwise the state is unreachable.
- While in `RD_CYC` or `INTA_CYC` with `wait_n` high, sample `data_in` every cycle into a holding register. Cycles with `wait_n` low do not update it.
- A cycle ends when `iorq_n` is sampled high. On that cycle:
  - Commit the holding register, or the latched write data, into the pending record.
  - Set the pending `io_rd`, `io_wr` or `inta` bit.
  - Return to `IDLE`.
- Overflow: a cycle ends with its direction bit already set and `STRICT`=1 → set `io_overflow`. The newer data overwrites the older in either case.
- `insn_retire`:
  - The pending record, including any cycle ending in the same clock, is presented on `rec_*` with `rec_valid`.
  - The pending record then clears.
  - An FSM cycle still in progress is not aborted. It commits into the next instruction's record.
- Simultaneous `iorq_n` rise and `insn_retire`: the completed cycle belongs to the retiring record.
- A record with no I/O still pulses `rec_valid`, with `rec_io_rd`=`rec_io_wr`=0.
- Reset mid-cycle: FSM forces to `IDLE` and the pending record clears. The partial cycle is discarded, with no overflow.

## Timing
- Reset values: `rec_valid`, `rec_io_rd`, `rec_io_wr`, `rec_inta`, `io_overflow` = 0. All address and data outputs = 0.
- Latency: `insn_retire` at cycle T → `rec_valid` and `rec_*` registered at T+1.
- `rec_*` holds its value until the next `rec_valid`.
- There is no back-pressure; the consumer must accept every `rec_valid`.
- Minimum I/O cycle is 2 clocks of `iorq_n` low. A 1-clock cycle records `addr` and whatever `data_in` was sampled; no error is raised.

## Configuration
- `Z80FI_INTA_CAPTURE_EN` defined:
  - Interrupt-acknowledge cycles are captured.
  - The vector byte appears on `rec_vector` with `rec_inta`=1 in the record of the instruction during which the acknowledge ends.
  - A second acknowledge within the same record sets `io_overflow` under `STRICT`.
- Not defined:
  - The `rec_inta` and `rec_vector` ports are absent.
  - `!m1_n && !iorq_n` is ignored; the FSM stays in `IDLE`.

## Structure
- The FSM state enum and the record struct (`io_rd`, `io_wr`, `inta`, addresses, data) go in the shared `z80fi_pkg`. This lets `z80fi` harness modules reuse the record type.
- One sub-module, `z80fi_io_cycle_fsm`:
  - Handles the strobe decode and data holding.
  - Emits a one-cycle `cyc_done` pulse with kind, address and data.
  - The top level accumulates these pulses into the per-instruction record and handles retirement.

## Test plan
- IN A,(C) with BC=0x12FE: read cycle at `addr`=0x12FE, `data_in`=0x5A, then retire → `rec_valid` at T+1 with `rec_io_rd`=1, `rec_raddr`=0x12FE, `rec_rdata`=0x5A, `rec_io_wr`=0.
- OUT (0x34),A with A=0x77: write at `addr`=0x7734 → record shows `rec_io_wr`=1, `rec_waddr`=0x7734, `rec_wdata`=0x77.
- Read with 3 `wait_n`-low clocks; `data_in` is 0xFF during the waits and 0x3C once `wait_n` is high → `rec_rdata`=0x3C.
- Two reads before retire with `STRICT`=1 → `io_overflow`=1 and the second read's data is recorded. Repeat with `STRICT`=0 → `io_overflow`=0.
- `iorq_n` rises in the same cycle as `insn_retire` → that cycle appears in the current record. The following record is empty: `rec_io_rd`=`rec_io_wr`=0.
- With `Z80FI_INTA_CAPTURE_EN`: acknowledge with vector 0xFF → `rec_inta`=1, `rec_vector`=0xFF, `rec_io_rd`=0. Without the macro, the same stimulus → empty record. Separately, assert `reset_n` low mid-read → all outputs return to 0 and the next record is empty.
